pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the NPC fetch front end. It holds the architectural fetch PC and offers it to the IFU over a valid/ready handshake. It advances by a fixed step on each accepted fetch and applies trap and branch/jump redirects with a one-cycle flush bubble. It replaces the bare select-and-register PC with stall, flush and handshake semantics.

## Interface
- `XLEN`, 32, PC width in bits
- `RESET_VEC`, 32'h8000_0000, PC value loaded on reset (XLEN bits)
- `STEP`, 4, byte increment per accepted fetch; must be a power of two ≥ 2
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `out_valid`  out  1  `out_pc` is a live fetch request
- `out_ready`  in  1  IFU accepts the request
- `out_pc`  out  XLEN  current fetch PC
- `out_pc_step`  out  XLEN  `out_pc + STEP`, modulo 2^XLEN (link value)
- `stall`  in  1  back-pressure from decode; suppresses `out_valid`
- `redir_valid`  in  1  branch/jump redirect request
- `redir_target`  in  XLEN  redirect target
- `trap_valid`  in  1  trap/mret redirect request
- `trap_target`  in  XLEN  trap target (mtvec/mepc)
- `misalign_err`  out  1  present only with `PC_GEN_MISALIGN_CHECK_EN`
- `misalign_addr`  out  XLEN  present only with `PC_GEN_MISALIGN_CHECK_EN`

## Operation
- States:
  - BOOT: after reset.
  - RUN: offering PC.
  - FLUSH: one bubble after a redirect.
  - ERR: misaligned redirect; present only with the macro.
- `out_valid = (state == RUN) & ~stall`.
- `fire = out_valid & out_ready`.
- Next-PC priority, highest first:
  - `trap_valid`: pc ← `trap_target`; state → FLUSH.
  - `redir_valid`: pc ← masked/checked `redir_target`; state → FLUSH.
  - `fire`: pc ← pc + STEP.
  - Otherwise: pc held.
- A redirect in the same cycle as `fire` wins; the accepted fetch is considered killed downstream.
- A redirect is accepted in any state, including BOOT, FLUSH and during `stall`.
- A redirect in FLUSH retargets and extends the bubble by one cycle.
- In RUN, `stall` holds pc and state; the request is re-offered, unchanged, when `stall` drops.
- While `out_valid = 1` and no redirect arrives, `out_pc` is stable until `fire`.
- Arithmetic is unsigned modulo 2^XLEN. 0xFFFF_FFFC + 4 → 0x0000_0000.
- `trap_target` low log2(STEP) bits are always forced to 0.

## Timing
- Reset: pc = RESET_VEC, state = BOOT, `out_valid` = 0, `misalign_err` = 0, `misalign_addr` = 0.
- BOOT → RUN unconditionally. First `out_valid` occurs 1 cycle after `rst` deasserts, unless a redirect occurs in BOOT.
- Redirect at cycle N:
  - Cycle N+1: FLUSH, `out_valid` = 0, `out_pc` = target.
  - Cycle N+2: RUN, `out_valid` = 1 (if no stall).
- Throughput is one fetch per cycle with `out_ready` held high.
- `rst` mid-operation overrides all inputs in that cycle.

## Configuration
- `PC_GEN_MISALIGN_CHECK_EN` undefined:
  - `redir_target` low log2(STEP) bits are silently cleared.
  - No ERR state; misalign ports are absent.
- `PC_GEN_MISALIGN_CHECK_EN` defined:
  - A redirect whose target low bits ≠ 0 is not applied; pc is unchanged.
  - State → ERR; `out_valid` = 0.
  - `misalign_err` = 1 and `misalign_addr` = raw target, both registered and held while in ERR.
  - In ERR, only `trap_valid` (→ FLUSH, clears `misalign_err`) or `rst` leaves the state; `redir_valid` is ignored.

## Structure
- Package `pc_gen_pkg`:
  - `pc_state_e` enum: BOOT, RUN, FLUSH, ERR.
  - `PC_DEFAULT_RESET_VEC`.
  - `PC_DEFAULT_STEP`.
- Sub-module `pc_next_sel`: combinational priority selector (trap > redirect > fire > hold), including masking/misalignment detect. Outputs next pc, next state and error flag.
- The top level holds only the pc, state and error registers.

## Test plan
- Reset then `out_ready` = 1 for 4 cycles → `out_pc` 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C; `out_valid` first high 1 cycle after `rst` low.
- `out_ready` = 0 for 3 cycles at pc 0x8000_0010, plus a `stall` pulse → `out_pc` held at 0x8000_0010; `out_valid` low exactly during `stall`.
- `redir_valid` with target 0x8000_0100 on a `fire` cycle → next cycle `out_valid` = 0, `out_pc` = 0x8000_0100; cycle after, `out_valid` = 1.
- `trap_valid` (0x8000_0200) and `redir_valid` (0x8000_0300) in the same cycle → `out_pc` = 0x8000_0200.
- Force pc 0xFFFF_FFFC via trap, then fire → `out_pc` = 0x0000_0000, `out_pc_step` = 0x0000_0004.
- Target 0x8000_0102:
  - Macro off: `out_pc` = 0x8000_0100.
  - Macro on: pc unchanged, `misalign_err` = 1, `misalign_addr` = 0x8000_0102 until `trap_valid`.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        ERR   = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_DEFAULT_RESET_VEC = 32'h8000_0000;
    localparam int unsigned PC_DEFAULT_STEP      = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request handshake between the PC generator and the IFU.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_step;

    modport master (output out_valid, output out_pc, output out_pc_step, input  out_ready);
    modport slave  (input  out_valid, input  out_pc, input  out_pc_step, output out_ready);
endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority selector: trap > redirect > fire > hold, with target alignment.
// Misaligned redirects raise an error state when PC_GEN_MISALIGN_CHECK_EN is defined.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = PC_DEFAULT_STEP
) (
    input  pc_state_e       state,
    input  logic [XLEN-1:0] pc,
    input  logic            fire,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
`ifdef PC_GEN_MISALIGN_CHECK_EN
    input  logic            err,
    input  logic [XLEN-1:0] err_addr,
    output logic            err_next,
    output logic [XLEN-1:0] err_addr_next,
`endif
    output logic [XLEN-1:0] pc_next,
    output pc_state_e       state_next
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);

    always_comb begin
        pc_next    = pc;
        state_next = state;
`ifdef PC_GEN_MISALIGN_CHECK_EN
        err_next      = err;
        err_addr_next = err_addr;
`endif
        case (state)
            BOOT:    state_next = RUN;
            FLUSH:   state_next = RUN;
            default: state_next = state;
        endcase

        if (fire) begin
            pc_next = pc + XLEN'(STEP);
        end

        // A redirect overrides the fetch accepted in the same cycle.
        if (trap_valid) begin
            pc_next    = trap_target & ~LOW_MASK;
            state_next = FLUSH;
`ifdef PC_GEN_MISALIGN_CHECK_EN
            err_next   = 1'b0;
`endif
        end else if (redir_valid) begin
`ifdef PC_GEN_MISALIGN_CHECK_EN
            if (state != ERR) begin
                if ((redir_target & LOW_MASK) != '0) begin
                    pc_next       = pc;
                    state_next    = ERR;
                    err_next      = 1'b1;
                    err_addr_next = redir_target;
                end else begin
                    pc_next    = redir_target;
                    state_next = FLUSH;
                end
            end
`else
            pc_next    = redir_target & ~LOW_MASK;
            state_next = FLUSH;
`endif
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the PC/state registers and offers the PC over valid/ready.
// Optional misaligned-redirect trapping is enabled by PC_GEN_MISALIGN_CHECK_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_DEFAULT_RESET_VEC),
    parameter int unsigned     STEP      = PC_DEFAULT_STEP
) (
    input  logic            clk,
    input  logic            rst,
    pc_gen_if.master        fetch,
    input  logic            stall,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target
`ifdef PC_GEN_MISALIGN_CHECK_EN
    ,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
`endif
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    pc_state_e       state;
    pc_state_e       state_next;
    logic            fire;

`ifdef PC_GEN_MISALIGN_CHECK_EN
    logic            err_next;
    logic [XLEN-1:0] err_addr_next;
`endif

    assign fetch.out_valid   = (state == RUN) & ~stall;
    assign fetch.out_pc      = pc;
    assign fetch.out_pc_step = pc + XLEN'(STEP);
    assign fire              = fetch.out_valid & fetch.out_ready;

    pc_next_sel #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_next_sel (
        .state         (state),
        .pc            (pc),
        .fire          (fire),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target),
        .trap_valid    (trap_valid),
        .trap_target   (trap_target),
`ifdef PC_GEN_MISALIGN_CHECK_EN
        .err           (misalign_err),
        .err_addr      (misalign_addr),
        .err_next      (err_next),
        .err_addr_next (err_addr_next),
`endif
        .pc_next       (pc_next),
        .state_next    (state_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VEC;
            state <= BOOT;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

`ifdef PC_GEN_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_err  <= err_next;
            misalign_addr <= err_addr_next;
        end
    end
`endif

endmodule
